// File: rtl/ioctl_stream_sink.sv
`default_nettype none
// =============================================================================
// ioctl_stream_sink - HPS download FIFO, paced SDRAM writer and MCU ROM mirror
// Rev 1.0
// =============================================================================
module ioctl_stream_sink #(
  parameter int DEPTH    = 4,
  parameter int ROM_BASE = 614400,
  parameter int ROM_SIZE = 4096,
  parameter int GAP      = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        mem_busy,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        rom_init,
  output logic [11:0] rom_init_addr,
  output logic [7:0]  rom_init_data,
  output logic        load_done,
  output logic        overflow,
  output logic [24:0] byte_count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              GW       = $clog2(GAP + 1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     WAIT_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP - 1);
  localparam logic [GW-1:0]   GAP_ONE  = GW'(1);
  localparam logic [25:0]     ROM_LO   = 26'(ROM_BASE);
  localparam logic [25:0]     ROM_HI   = 26'(ROM_BASE + ROM_SIZE);
  localparam logic [11:0]     ROM_OFS  = 12'(ROM_BASE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [32:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [GW-1:0] gap_cnt;
  logic          dl_q, flush_pend;
  logic [11:0]   rom_addr_q;
  logic [7:0]    rom_data_q;

  logic          full, empty, pop, push_ok, dl_fall, dl_rise, more, expired, in_rom;
  logic [24:0]   head_addr;
  logic [7:0]    head_data;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop     = (state == WRITE);
  // A pop in the same cycle frees a slot, so a strobe at full is still taken.
  assign push_ok = ioctl_wr && (!full || pop);
  assign dl_fall = dl_q && !ioctl_download;
  assign dl_rise = !dl_q && ioctl_download;

  assign {head_addr, head_data} = fifo_mem[rd_ptr];

  assign in_rom = ({1'b0, head_addr} >= ROM_LO) && ({1'b0, head_addr} < ROM_HI);

  assign mem_we        = pop;
  assign mem_addr      = pop ? head_addr : '0;
  assign mem_din       = pop ? head_data : '0;
  assign rom_init      = pop && in_rom;
  assign rom_init_addr = rom_init ? (head_addr[11:0] - ROM_OFS) : rom_addr_q;
  assign rom_init_data = rom_init ? head_data : rom_data_q;

  // In WRITE the head is leaving, so "more" must look past it.
  assign more    = (state == WRITE) ? (count > CNT_ONE) : !empty;
  assign expired = ((state == HOLD) && (gap_cnt <= GAP_ONE)) ||
                   ((state == WRITE) && (GAP == 1));

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (!push_ok && pop) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        if (dl_fall) begin
          state_nxt = FLUSH;
        end else if (!empty && !mem_busy) begin
          state_nxt = WRITE;
        end
      end
      WRITE: state_nxt = HOLD;
      HOLD:  state_nxt = HOLD;
      FLUSH: begin
        if (empty) begin
          load_done = 1'b1;
          state_nxt = IDLE;
        end else if (!mem_busy) begin
          state_nxt = WRITE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (expired) begin
      if (more && !mem_busy) begin
        state_nxt = WRITE;
      end else if (more) begin
        state_nxt = HOLD;
      end else if (flush_pend || dl_fall) begin
        state_nxt = FLUSH;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      gap_cnt    <= '0;
      dl_q       <= 1'b0;
      flush_pend <= 1'b0;
      ioctl_wait <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      ioctl_wait <= (count_nxt >= WAIT_CNT);
      dl_q       <= ioctl_download;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (state == WRITE) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == HOLD) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_ONE;
      end
      if (load_done) begin
        flush_pend <= 1'b0;
      end else if (dl_fall) begin
        flush_pend <= 1'b1;
      end
      overflow <= (overflow && !dl_rise) || (ioctl_wr && !push_ok);
      if (dl_rise) begin
        byte_count <= push_ok ? 25'd1 : 25'd0;
      end else if (push_ok) begin
        byte_count <= byte_count + 25'd1;
      end
      if (rom_init) begin
        rom_addr_q <= rom_init_addr;
        rom_data_q <= rom_init_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ioctl_stream_sink.sv
`default_nettype none
// =============================================================================
// tb_ioctl_stream_sink - scoreboard bench for the ioctl download sink
// Rev 1.0
// =============================================================================
module tb_ioctl_stream_sink;

  localparam int DEPTH    = 4;
  localparam int ROM_BASE = 614400;
  localparam int ROM_SIZE = 4096;
  localparam int GAP      = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_busy;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        rom_init;
  logic [11:0] rom_init_addr;
  logic [7:0]  rom_init_data;
  logic        load_done;
  logic        overflow;
  logic [24:0] byte_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [32:0] sb[$];
  int          we_times[$];

  ioctl_stream_sink #(
    .DEPTH(DEPTH), .ROM_BASE(ROM_BASE), .ROM_SIZE(ROM_SIZE), .GAP(GAP)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .mem_busy(mem_busy), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .rom_init(rom_init),
    .rom_init_addr(rom_init_addr), .rom_init_data(rom_init_data),
    .load_done(load_done), .overflow(overflow), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  // Write monitor: every mem_we must match the oldest expected byte.
  logic [32:0] m_e;
  logic [11:0] m_last_ra;
  logic [7:0]  m_last_rd;
  logic [11:0] m_ra;
  logic [7:0]  m_rd;
  logic        m_win;
  int          m_a;
  int          m_ofs;
  always @(negedge clk_sys) begin
    if (reset_n !== 1'b1) begin
      m_last_ra = '0;
      m_last_rd = '0;
    end else if (mem_we === 1'b1) begin
      we_times.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: mem_addr=%h mem_din=%h, required no write", mem_addr, mem_din);
      end else begin
        m_e = sb.pop_front();
        if (mem_addr !== m_e[32:8] || mem_din !== m_e[7:0]) begin
          failures++;
          $display("FAIL write_data: got %h/%h, required %h/%h", mem_addr, mem_din, m_e[32:8], m_e[7:0]);
        end
        m_a   = int'(m_e[32:8]);
        m_win = (m_a >= ROM_BASE) && (m_a < ROM_BASE + ROM_SIZE);
        m_ofs = m_a - ROM_BASE;
        m_ra  = m_win ? m_ofs[11:0] : m_last_ra;
        m_rd  = m_win ? m_e[7:0] : m_last_rd;
        checks++;
        if (rom_init !== m_win || rom_init_addr !== m_ra || rom_init_data !== m_rd) begin
          failures++;
          $display("FAIL rom_mirror: addr=%h got %b/%h/%h, required %b/%h/%h", m_e[32:8],
                   rom_init, rom_init_addr, rom_init_data, m_win, m_ra, m_rd);
        end
        if (m_win) begin
          m_last_ra = m_ra;
          m_last_rd = m_rd;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_download();
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_drain(output bit ok);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    ok = (sb.size() == 0);
    repeat (GAP + 2) tick();
  endtask

  task automatic wait_load_done(output bit seen, output int lat);
    lat = 0;
    while (load_done !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    seen = (load_done === 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (mem_we !== 0 || rom_init !== 0 || load_done !== 0 || ioctl_wait !== 0) begin
      failures++;
      $display("FAIL reset_strobes: got we=%b rom=%b done=%b wait=%b, required all 0",
               mem_we, rom_init, load_done, ioctl_wait);
    end
    checks++;
    if (mem_addr !== 0 || mem_din !== 0 || rom_init_addr !== 0 || rom_init_data !== 0 ||
        overflow !== 0 || byte_count !== 0) begin
      failures++;
      $display("FAIL reset_values: got %h %h %h %h %b %h, required all 0", mem_addr, mem_din,
               rom_init_addr, rom_init_data, overflow, byte_count);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit seen;
    int lat;
    start_download();
    ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'hA5;
    sb.push_back({25'h10, 8'hA5});
    tick();
    ioctl_wr = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL single_early: mem_we=%b one cycle after push, required 0", mem_we);
    end
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 25'h10 || mem_din !== 8'hA5 || rom_init !== 1'b0) begin
      failures++;
      $display("FAIL single_latency: got we=%b %h/%h rom=%b, required 1 010/a5 0",
               mem_we, mem_addr, mem_din, rom_init);
    end
    tick();
    ioctl_download = 1'b0;
    wait_load_done(seen, lat);
    checks++;
    if (!seen || lat != GAP - 1) begin
      failures++;
      $display("FAIL single_done: seen=%b after %0d more cycles, required 1 after %0d", seen, lat, GAP - 1);
    end
    checks++;
    if (byte_count !== 25'd1) begin
      failures++;
      $display("FAIL single_count: byte_count=%0d, required 1", byte_count);
    end
    tick();
    checks++;
    if (load_done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse: load_done=%b, required 0", load_done);
    end
  endtask

  task automatic flush_and_check(input string name);
    bit seen;
    int lat;
    ioctl_download = 1'b0;
    wait_load_done(seen, lat);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done: load_done=%b, required 1 within 30 cycles", name, load_done);
    end
    tick();
  endtask

  task automatic test_burst_drop();
    bit ok;
    start_download();
    // Drain takes one byte per GAP cycles; strobes 6 and 7 meet a full FIFO.
    for (int i = 0; i < 8; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h100 + 25'(i); ioctl_dout = 8'h30 + 8'(i);
      if (i < 6) sb.push_back({ioctl_addr, ioctl_dout});
      tick();
      if (i == 1) begin
        checks++;
        if (ioctl_wait !== 1'b0) begin
          failures++;
          $display("FAIL burst_wait_low: ioctl_wait=%b at occupancy 2, required 0", ioctl_wait);
        end
      end
      if (i == 3) begin
        checks++;
        if (ioctl_wait !== 1'b1) begin
          failures++;
          $display("FAIL burst_wait_high: ioctl_wait=%b at occupancy 3, required 1", ioctl_wait);
        end
      end
    end
    ioctl_wr = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL burst_drain: %0d writes missing, required 0", sb.size());
    end
    checks++;
    if (overflow !== 1'b1 || byte_count !== 25'd6) begin
      failures++;
      $display("FAIL burst_overflow: overflow=%b count=%0d, required 1 and 6", overflow, byte_count);
    end
    flush_and_check("burst_drop");
  endtask

  task automatic test_burst_wait();
    bit ok;
    int n;
    int guard;
    start_download();
    checks++;
    if (overflow !== 1'b0 || byte_count !== 25'd0) begin
      failures++;
      $display("FAIL rise_clear: overflow=%b count=%0d, required 0 and 0", overflow, byte_count);
    end
    we_times.delete();
    n = 0;
    guard = 0;
    while (n < 8 && guard < 200) begin
      if (ioctl_wait === 1'b0) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'h200 + 25'(n); ioctl_dout = 8'h50 + 8'(n);
        sb.push_back({ioctl_addr, ioctl_dout});
        n++;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
      guard++;
    end
    ioctl_wr = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok || we_times.size() != 8) begin
      failures++;
      $display("FAIL paced_writes: %0d writes, %0d missing, required 8 and 0", we_times.size(), sb.size());
    end
    for (int i = 1; i < 8 && i < we_times.size(); i++) begin
      checks++;
      if (we_times[i] - we_times[i-1] != GAP) begin
        failures++;
        $display("FAIL paced_spacing: write %0d came %0d cycles after previous, required %0d",
                 i, we_times[i] - we_times[i-1], GAP);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL paced_overflow: overflow=%b, required 0", overflow);
    end
    flush_and_check("burst_wait");
  endtask

  task automatic test_rom_window();
    bit ok;
    logic [24:0] addrs [4];
    addrs[0] = 25'd614399; addrs[1] = 25'd614400; addrs[2] = 25'd618495; addrs[3] = 25'd618496;
    start_download();
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = addrs[i]; ioctl_dout = 8'h11 * 8'(i + 1);
      sb.push_back({ioctl_addr, ioctl_dout});
      tick();
      ioctl_wr = 1'b0;
      repeat (GAP) tick();
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rom_drain: %0d writes missing, required 0", sb.size());
    end
    checks++;
    if (rom_init !== 1'b0 || rom_init_addr !== 12'hFFF || rom_init_data !== 8'h33) begin
      failures++;
      $display("FAIL rom_hold: got %b/%h/%h, required 0/fff/33", rom_init, rom_init_addr, rom_init_data);
    end
    flush_and_check("rom");
  endtask

  task automatic test_busy();
    bit ok;
    start_download();
    mem_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ioctl_wr = (i < 2);
      ioctl_addr = 25'h300 + 25'(i); ioctl_dout = 8'h70 + 8'(i);
      if (i < 2) sb.push_back({ioctl_addr, ioctl_dout});
      tick();
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("FAIL busy_stall: mem_we=%b in busy cycle %0d, required 0", mem_we, i);
      end
    end
    ioctl_wr = 1'b0;
    mem_busy = 1'b0;
    tick();
    checks++;
    if (mem_we !== 1'b1) begin
      failures++;
      $display("FAIL busy_release: mem_we=%b cycle after busy fell, required 1", mem_we);
    end
    for (int k = 1; k <= GAP; k++) begin
      tick();
      checks++;
      if (mem_we !== (k == GAP)) begin
        failures++;
        $display("FAIL busy_second: mem_we=%b %0d cycles after first, required %b", mem_we, k, k == GAP);
      end
    end
    wait_drain(ok);
    flush_and_check("busy");
  endtask

  task automatic test_full_push_pop();
    bit ok;
    start_download();
    mem_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h400 + 25'(i); ioctl_dout = 8'h90 + 8'(i);
      sb.push_back({ioctl_addr, ioctl_dout});
      tick();
    end
    ioctl_wr = 1'b0;
    mem_busy = 1'b0;
    tick();
    checks++;
    if (mem_we !== 1'b1 || ioctl_wait !== 1'b1) begin
      failures++;
      $display("FAIL full_pop: mem_we=%b wait=%b, required 1 and 1", mem_we, ioctl_wait);
    end
    ioctl_wr = 1'b1; ioctl_addr = 25'h4FF; ioctl_dout = 8'hEE;
    sb.push_back({ioctl_addr, ioctl_dout});
    tick();
    ioctl_wr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || byte_count !== 25'd5 || ioctl_wait !== 1'b1) begin
      failures++;
      $display("FAIL full_push: overflow=%b count=%0d wait=%b, required 0 5 1", overflow, byte_count, ioctl_wait);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_drain: %0d writes missing, required 0", sb.size());
    end
    flush_and_check("full");
  endtask

  task automatic test_reset_mid_flush();
    int bad;
    start_download();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h500 + 25'(i); ioctl_dout = 8'hC0 + 8'(i);
      tick();
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 0 || mem_addr !== 0 || mem_din !== 0 || rom_init !== 0 || rom_init_addr !== 0 ||
        rom_init_data !== 0 || load_done !== 0 || overflow !== 0 || byte_count !== 0 || ioctl_wait !== 0) begin
      failures++;
      $display("FAIL async_reset: we=%b addr=%h din=%h rom=%b done=%b ovf=%b cnt=%0d wait=%b, required all 0",
               mem_we, mem_addr, mem_din, rom_init, load_done, overflow, byte_count, ioctl_wait);
    end
    mem_busy = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_we !== 1'b0 || load_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_discard: %0d cycles with mem_we or load_done after reset, required 0", bad);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    mem_busy = 1'b0;
    test_reset();
    test_single();
    test_burst_drop();
    test_burst_wait();
    test_rom_window();
    test_busy();
    test_full_push_pop();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
